// File: rtl/alu_exec_unit_pkg.sv
// Shared types and combinational helpers for alu_exec_unit.
// The ALU_* codes are the ALU control unit's shared defines.v values; skipped if that header is already loaded.
`ifndef ALU_ADD
`define ALU_AND  4'b0000
`define ALU_OR   4'b0001
`define ALU_ADD  4'b0010
`define ALU_XOR  4'b0011
`define ALU_SLL  4'b0100
`define ALU_SRL  4'b0101
`define ALU_SUB  4'b0110
`define ALU_SLT  4'b0111
`define ALU_SLTU 4'b1000
`define ALU_SRA  4'b1001
`define ALU_PASS 4'b1010
`endif

package alu_exec_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_kind_e;

  typedef struct packed {
    word_t result;
    logic  zero;
    logic  carry;
    logic  overflow;
    logic  sign;
  } alu_out_t;

  // Flags for every op that cannot carry or overflow.
  function automatic alu_out_t word_flags(input word_t r);
    alu_out_t o;
    o          = '0;
    o.result   = r;
    o.zero     = (r == '0);
    o.sign     = r[31];
    return o;
  endfunction

  // All single-cycle non-shift operations; unknown codes give zero.
  function automatic alu_out_t alu_compute(input logic [3:0] op, input word_t a, input word_t b);
    alu_out_t    o;
    logic [32:0] sum;
    word_t       r;
    logic        c;
    logic        v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      `ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (r[31] != a[31]);
      end
      `ALU_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r   = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (r[31] != a[31]);
      end
      `ALU_PASS: r = b;
      `ALU_OR:   r = a | b;
      `ALU_AND:  r = a & b;
      `ALU_XOR:  r = a ^ b;
      `ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      `ALU_SLTU: r = {31'd0, (a < b)};
      default:   r = '0;
    endcase
    o          = word_flags(r);
    o.carry    = c;
    o.overflow = v;
    return o;
  endfunction

endpackage

// File: rtl/alu_exec_unit_iter_shifter.sv
// One-bit-per-cycle shifter: loads operand and count, then steps until the count hits zero.
// last_o marks the cycle whose next_o is the final shifted value.
module alu_iter_shifter
  import alu_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        abort_i,
  input  shift_kind_e kind_i,
  input  word_t       data_i,
  input  logic [4:0]  amt_i,
  output word_t       next_o,
  output logic        last_o
);

  word_t       sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  shift_kind_e kind_q, kind_d;
  word_t       stepped;

  always_comb begin
    case (kind_q)
      SH_LL:   stepped = {sh_q[30:0], 1'b0};
      SH_RL:   stepped = {1'b0, sh_q[31:1]};
      default: stepped = {sh_q[31], sh_q[31:1]};
    endcase
  end

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (load_i) begin
      sh_d   = data_i;
      cnt_d  = amt_i;
      kind_d = kind_i;
    end else if (abort_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      sh_d  = stepped;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift register resets along with the counter so a reset mid-shift leaves no stale operand.
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

  assign next_o = stepped;
  assign last_o = (cnt_q == 5'd1);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: registered result/flags with a done pulse; shifts iterate unless BARREL_SHIFT_EN is defined.
// Non-shift ops and zero-length shifts always finish one cycle after acceptance.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      ALU_selection,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            overflow_flag,
  output logic            sign_flag,
  output logic            busy,
  output logic            done
);

  state_e      state_q, state_d;
  alu_out_t    out_q, out_d;
  logic        done_q, done_d;
  logic        accept;
  logic        is_shift;
  logic        iter_start;
  logic        sh_last;
  logic [4:0]  shamt;
  word_t       shift_res;
  word_t       sh_next;
  shift_kind_e sh_kind;

  assign shamt  = b[4:0];
  assign accept = start && !flush && (state_q == ST_IDLE);

  always_comb begin
    is_shift = 1'b0;
    sh_kind  = SH_LL;
    case (ALU_selection)
      `ALU_SLL: begin is_shift = 1'b1; sh_kind = SH_LL; end
      `ALU_SRL: begin is_shift = 1'b1; sh_kind = SH_RL; end
      `ALU_SRA: begin is_shift = 1'b1; sh_kind = SH_RA; end
      default: ;
    endcase
  end

`ifdef BARREL_SHIFT_EN
  always_comb begin
    case (sh_kind)
      SH_LL:   shift_res = a << shamt;
      SH_RL:   shift_res = a >> shamt;
      default: shift_res = word_t'($signed(a) >>> shamt);
    endcase
  end

  assign iter_start = 1'b0;
  assign sh_last    = 1'b0;
  assign sh_next    = '0;
`else
  // Only a zero-length shift completes directly, and it returns a unchanged.
  assign shift_res  = a;
  assign iter_start = accept && is_shift && (shamt != 5'd0);

  alu_iter_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (iter_start),
    .abort_i (flush),
    .kind_i  (sh_kind),
    .data_i  (a),
    .amt_i   (shamt),
    .next_o  (sh_next),
    .last_o  (sh_last)
  );
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (iter_start) begin
            state_d = ST_SHIFT;
          end else begin
            out_d  = is_shift ? word_flags(shift_res) : alu_compute(ALU_selection, a, b);
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (sh_last) begin
          state_d = ST_IDLE;
          out_d   = word_flags(sh_next);
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign result        = out_q.result;
  assign zero_flag     = out_q.zero;
  assign carry_flag    = out_q.carry;
  assign overflow_flag = out_q.overflow;
  assign sign_flag     = out_q.sign;
  assign busy          = (state_q == ST_SHIFT);
  assign done          = done_q;

endmodule
